// File: rtl/mem_pkg.sv
// Shared types and constants for the memory access initiator and its arbiter.
package mem_pkg;

   localparam int unsigned WORD_BYTES_LOG2 = 2;
   localparam logic [31:0] DATA_BASE_DEF   = 32'h1000_0000;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   typedef enum logic {
      SRC_IF = 1'b0,
      SRC_D  = 1'b1
   } src_e;

   // A byte address is a legal word access only when its low offset bits are zero.
   function automatic logic is_misaligned(input logic [WORD_BYTES_LOG2-1:0] offset);
      return offset != '0;
   endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: on a tie, the side not granted last time wins.
module rr_arbiter2
   import mem_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic en,
   input  logic req_if,
   input  logic req_d,
   output logic gnt_if_c,
   output logic gnt_d_c
);

   src_e last_q;

   always_comb begin
      gnt_if_c = 1'b0;
      gnt_d_c  = 1'b0;
      if (en) begin
         if (req_if && req_d) begin
            if (last_q == SRC_D) gnt_if_c = 1'b1;
            else                 gnt_d_c  = 1'b1;
         end else begin
            gnt_if_c = req_if;
            gnt_d_c  = req_d;
         end
      end
   end

   // Starting with DATA as last winner hands the first tie to fetch.
   always_ff @(posedge clock) begin
      if (reset) begin
         last_q <= SRC_D;
      end else if (gnt_if_c) begin
         last_q <= SRC_IF;
      end else if (gnt_d_c) begin
         last_q <= SRC_D;
      end
   end

endmodule

// File: rtl/mem_access_initiator.sv
// Single-outstanding bus master arbitrating fetch and load/store ports onto the
// shared memory system: accept, one ACCESS cycle, then a one-cycle response.
module mem_access_initiator
   import mem_pkg::*;
#(
   parameter int unsigned       WIDTH     = 32,
   parameter logic [WIDTH-1:0]  DATA_BASE = WIDTH'(DATA_BASE_DEF),
   parameter int unsigned       CNT_W     = 16
)(
   input  logic             clock,
   input  logic             reset,
   input  logic             if_req_i,
   input  logic [WIDTH-1:0] if_addr_i,
   output logic             if_gnt_o,
   output logic             if_rvalid_o,
   output logic [WIDTH-1:0] if_rdata_o,
   output logic             if_err_o,
   input  logic             d_req_i,
   input  logic             d_we_i,
   input  logic [WIDTH-1:0] d_addr_i,
   input  logic [WIDTH-1:0] d_wdata_i,
   output logic             d_gnt_o,
   output logic             d_rvalid_o,
   output logic [WIDTH-1:0] d_rdata_o,
   output logic             d_err_o,
   output logic [WIDTH-1:0] mem_addr_o,
   output logic [WIDTH-1:0] mem_wdata_o,
   output logic             mem_we_o,
   input  logic [WIDTH-1:0] mem_rdata_i,
   output logic [CNT_W-1:0] conflict_cnt_o
);

   state_e           state_q, state_d;
   src_e             src_q;
   logic [WIDTH-1:0] addr_q, wdata_q;
   logic             we_q, err_q;
   logic [WIDTH-1:0] if_rdata_q, d_rdata_q;
   logic [CNT_W-1:0] cnt_q;

   logic             arb_en_c, gnt_if_c, gnt_d_c, accept_c;
   logic [WIDTH-1:0] acc_addr_c, acc_wdata_c;
   logic             acc_we_c, acc_err_c;

   // No acceptance while an access is in flight or reset is held.
   assign arb_en_c = !reset && (state_q != ACCESS);

   rr_arbiter2 u_arb (
      .clock    (clock),
      .reset    (reset),
      .en       (arb_en_c),
      .req_if   (if_req_i),
      .req_d    (d_req_i),
      .gnt_if_c (gnt_if_c),
      .gnt_d_c  (gnt_d_c)
   );

   assign if_gnt_o = gnt_if_c;
   assign d_gnt_o  = gnt_d_c;
   assign accept_c = gnt_if_c || gnt_d_c;

   // Winner's payload and fault classification, evaluated in the accepting cycle.
   assign acc_addr_c  = gnt_d_c ? d_addr_i : if_addr_i;
   assign acc_we_c    = gnt_d_c && d_we_i;
   assign acc_wdata_c = gnt_d_c ? d_wdata_i : '0;
   assign acc_err_c   = is_misaligned(acc_addr_c[WORD_BYTES_LOG2-1:0]) ||
                        (acc_we_c && (d_addr_i < DATA_BASE));

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      if_rvalid_o = 1'b0;
      d_rvalid_o  = 1'b0;
      if_err_o    = 1'b0;
      d_err_o     = 1'b0;
      mem_we_o    = 1'b0;
      case (state_q)
         IDLE: begin
            state_d = accept_c ? ACCESS : IDLE;
         end
         ACCESS: begin
            state_d  = RESP;
            mem_we_o = we_q && !err_q && !reset;
         end
         RESP: begin
            state_d = accept_c ? ACCESS : IDLE;
            if (src_q == SRC_IF) begin
               if_rvalid_o = 1'b1;
               if_err_o    = err_q;
            end else begin
               d_rvalid_o = 1'b1;
               d_err_o    = err_q;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Access payload registers, loaded on acceptance.
   always_ff @(posedge clock) begin
      if (reset) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         src_q   <= SRC_D;
      end else if (accept_c) begin
         addr_q  <= acc_addr_c;
         wdata_q <= acc_wdata_c;
         we_q    <= acc_we_c;
         err_q   <= acc_err_c;
         src_q   <= gnt_d_c ? SRC_D : SRC_IF;
      end
   end

   // Read data lands in the source port's register at the end of ACCESS; stores leave it alone.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else if ((state_q == ACCESS) && !we_q) begin
         if (src_q == SRC_IF) if_rdata_q <= mem_rdata_i;
         else                 d_rdata_q  <= mem_rdata_i;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (accept_c && if_req_i && d_req_i && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign mem_addr_o     = addr_q;
   assign mem_wdata_o    = wdata_q;
   assign if_rdata_o     = if_rdata_q;
   assign d_rdata_o      = d_rdata_q;
   assign conflict_cnt_o = cnt_q;

endmodule

// File: tb/tb_mem_access_initiator.sv
// Directed bench for mem_access_initiator with a small ROM/RAM model behind the bus.
module tb_mem_access_initiator;

   logic        clock = 1'b0;
   logic        reset;
   logic        if_req_i;
   logic [31:0] if_addr_i;
   logic        if_gnt_o, if_rvalid_o, if_err_o;
   logic [31:0] if_rdata_o;
   logic        d_req_i, d_we_i;
   logic [31:0] d_addr_i, d_wdata_i;
   logic        d_gnt_o, d_rvalid_o, d_err_o;
   logic [31:0] d_rdata_o;
   logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
   logic        mem_we_o;
   logic [15:0] conflict_cnt_o;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] ram [16] = '{default: 32'h0};
   int          we_count = 0;

   mem_access_initiator dut (
      .clock          (clock),
      .reset          (reset),
      .if_req_i       (if_req_i),
      .if_addr_i      (if_addr_i),
      .if_gnt_o       (if_gnt_o),
      .if_rvalid_o    (if_rvalid_o),
      .if_rdata_o     (if_rdata_o),
      .if_err_o       (if_err_o),
      .d_req_i        (d_req_i),
      .d_we_i         (d_we_i),
      .d_addr_i       (d_addr_i),
      .d_wdata_i      (d_wdata_i),
      .d_gnt_o        (d_gnt_o),
      .d_rvalid_o     (d_rvalid_o),
      .d_rdata_o      (d_rdata_o),
      .d_err_o        (d_err_o),
      .mem_addr_o     (mem_addr_o),
      .mem_wdata_o    (mem_wdata_o),
      .mem_we_o       (mem_we_o),
      .mem_rdata_i    (mem_rdata_i),
      .conflict_cnt_o (conflict_cnt_o)
   );

   always #5 clock = ~clock;

   // ROM word at 0x0040_0000, 16-word RAM at DATA_BASE, address-derived pattern elsewhere.
   always_comb begin
      if (mem_addr_o == 32'h0040_0000)
         mem_rdata_i = 32'hDEAD_BEEF;
      else if (mem_addr_o[31:6] == 26'h040_0000)
         mem_rdata_i = ram[mem_addr_o[5:2]];
      else
         mem_rdata_i = mem_addr_o ^ 32'h5A5A_5A5A;
   end

   always @(posedge clock) begin
      if (mem_we_o) begin
         we_count <= we_count + 1;
         if (mem_addr_o[31:6] == 26'h040_0000) ram[mem_addr_o[5:2]] <= mem_wdata_o;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic f_access(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_rdata, input logic exp_err);
      logic got;
      got = 1'b0;
      if_req_i  = 1'b1;
      if_addr_i = addr;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         if (if_gnt_o) got = 1'b1;
         else tick();
      end
      check_eq({tag, "_gnt"}, 32'(got), 32'd1);
      tick();
      if_req_i = 1'b0;
      @(negedge clock);
      check_eq({tag, "_addr"}, mem_addr_o, addr);
      check_eq({tag, "_rv_early"}, 32'(if_rvalid_o), 32'd0);
      @(posedge clock);
      @(negedge clock);
      check_eq({tag, "_rvalid"}, 32'(if_rvalid_o), 32'd1);
      check_eq({tag, "_err"}, 32'(if_err_o), 32'(exp_err));
      check_eq({tag, "_rdata"}, if_rdata_o, exp_rdata);
      check_eq({tag, "_d_rv"}, 32'(d_rvalid_o), 32'd0);
      tick();
   endtask

   task automatic d_access(input string tag, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic chk_rdata, input logic [31:0] exp_rdata);
      logic got;
      got = 1'b0;
      d_req_i   = 1'b1;
      d_we_i    = we;
      d_addr_i  = addr;
      d_wdata_i = wdata;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clock);
         if (d_gnt_o) got = 1'b1;
         else tick();
      end
      check_eq({tag, "_gnt"}, 32'(got), 32'd1);
      tick();
      d_req_i = 1'b0;
      @(negedge clock);
      check_eq({tag, "_addr"}, mem_addr_o, addr);
      check_eq({tag, "_rv_early"}, 32'(d_rvalid_o), 32'd0);
      @(posedge clock);
      @(negedge clock);
      check_eq({tag, "_rvalid"}, 32'(d_rvalid_o), 32'd1);
      check_eq({tag, "_err"}, 32'(d_err_o), 32'(exp_err));
      check_eq({tag, "_if_rv"}, 32'(if_rvalid_o), 32'd0);
      if (chk_rdata) check_eq({tag, "_rdata"}, d_rdata_o, exp_rdata);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int we_before;
      int grants;
      logic exp_d;

      reset     = 1'b1;
      if_req_i  = 1'b0;
      if_addr_i = '0;
      d_req_i   = 1'b0;
      d_we_i    = 1'b0;
      d_addr_i  = '0;
      d_wdata_i = '0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;

      @(negedge clock);
      check_eq("rst_if_rv", 32'(if_rvalid_o), 32'd0);
      check_eq("rst_d_rv", 32'(d_rvalid_o), 32'd0);
      check_eq("rst_we", 32'(mem_we_o), 32'd0);
      check_eq("rst_addr", mem_addr_o, 32'd0);
      check_eq("rst_wdata", mem_wdata_o, 32'd0);
      check_eq("rst_if_rdata", if_rdata_o, 32'd0);
      check_eq("rst_d_rdata", d_rdata_o, 32'd0);
      check_eq("rst_cnt", 32'(conflict_cnt_o), 32'd0);
      tick();

      f_access("fetch_rom", 32'h0040_0000, 32'hDEAD_BEEF, 1'b0);

      we_before = we_count;
      d_access("store_ram", 1'b1, 32'h1000_0004, 32'h1234_5678, 1'b0, 1'b1, 32'h0);
      check_eq("store_we_cycles", 32'(we_count - we_before), 32'd1);
      check_eq("store_ram_word", ram[1], 32'h1234_5678);
      d_access("load_ram", 1'b0, 32'h1000_0004, 32'h0, 1'b0, 1'b1, 32'h1234_5678);

      // Both ports held: grants must alternate starting with fetch.
      if_req_i  = 1'b1;
      if_addr_i = 32'h0040_0000;
      d_req_i   = 1'b1;
      d_we_i    = 1'b0;
      d_addr_i  = 32'h1000_0004;
      grants    = 0;
      exp_d     = 1'b0;
      for (int c = 0; c < 40 && grants < 6; c++) begin
         @(negedge clock);
         if (if_gnt_o || d_gnt_o) begin
            check_eq("arb_order", 32'(d_gnt_o), 32'(exp_d));
            check_eq("arb_onehot", 32'(if_gnt_o && d_gnt_o), 32'd0);
            exp_d = !exp_d;
            grants++;
         end
         tick();
      end
      if_req_i = 1'b0;
      d_req_i  = 1'b0;
      check_eq("arb_grants", 32'(grants), 32'd6);
      repeat (3) tick();
      check_eq("conflict_cnt", 32'(conflict_cnt_o), 32'd6);
      check_eq("arb_if_rdata", if_rdata_o, 32'hDEAD_BEEF);
      check_eq("arb_d_rdata", d_rdata_o, 32'h1234_5678);

      we_before = we_count;
      d_access("rom_store", 1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 1'b1, 32'h1234_5678);
      d_access("misalign_ld", 1'b0, 32'h1000_0002, 32'h0, 1'b1, 1'b0, 32'h0);
      check_eq("fault_no_we", 32'(we_count - we_before), 32'd0);
      check_eq("fault_ram_kept", ram[1], 32'h1234_5678);
      check_eq("fault_cnt_kept", 32'(conflict_cnt_o), 32'd6);

      // Reset lands on the ACCESS cycle of a store.
      we_before = we_count;
      d_req_i   = 1'b1;
      d_we_i    = 1'b1;
      d_addr_i  = 32'h1000_0008;
      d_wdata_i = 32'hCAFE_F00D;
      @(negedge clock);
      check_eq("rst_store_gnt", 32'(d_gnt_o), 32'd1);
      tick();
      d_req_i = 1'b0;
      reset   = 1'b1;
      @(negedge clock);
      check_eq("rst_store_we_gated", 32'(mem_we_o), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clock);
      check_eq("rst2_d_rv", 32'(d_rvalid_o), 32'd0);
      check_eq("rst2_we", 32'(mem_we_o), 32'd0);
      check_eq("rst2_addr", mem_addr_o, 32'd0);
      check_eq("rst2_wdata", mem_wdata_o, 32'd0);
      check_eq("rst2_cnt", 32'(conflict_cnt_o), 32'd0);
      check_eq("rst2_d_rdata", d_rdata_o, 32'd0);
      check_eq("rst2_if_rdata", if_rdata_o, 32'd0);
      check_eq("rst2_no_commit", ram[2], 32'd0);
      check_eq("rst2_we_count", 32'(we_count - we_before), 32'd0);
      tick();
      @(negedge clock);
      check_eq("rst2_no_late_rv", 32'(d_rvalid_o), 32'd0);
      tick();
      f_access("fetch_after_rst", 32'h0040_0000, 32'hDEAD_BEEF, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_initiator.md
# mem_access_initiator

Bus master that drives the shared single-port memory system (program ROM below `DATA_BASE`, data RAM at and above it). Arbitrates between the core's instruction-fetch port and load/store port, issues one word access at a time, captures read data and returns a response pulse to the winning port. It sits between the datapath and the memory system and is the only block that drives the memory system's address, write-data and write-enable inputs.

## Interface
- `WIDTH`, 32, address and data width
- `DATA_BASE`, 32'h1000_0000, lowest RAM address; below it is read-only ROM
- `CNT_W`, 16, width of the conflict counter

- `clock` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `if_req_i` in 1: fetch request; held with `if_addr_i` until `if_gnt_o`
- `if_addr_i` in WIDTH: fetch byte address
- `if_gnt_o` out 1: fetch request accepted this cycle
- `if_rvalid_o` out 1: one-cycle fetch response
- `if_rdata_o` out WIDTH: fetched word, valid with `if_rvalid_o`, held otherwise
- `if_err_o` out 1: fetch fault, valid with `if_rvalid_o`
- `d_req_i` in 1: data request; held with `d_we_i`, `d_addr_i`, `d_wdata_i` until `d_gnt_o`
- `d_we_i` in 1: 1 = store, 0 = load
- `d_addr_i` in WIDTH: data byte address
- `d_wdata_i` in WIDTH: store data
- `d_gnt_o` out 1: data request accepted this cycle
- `d_rvalid_o` out 1: one-cycle data response; pulses for loads and stores
- `d_rdata_o` out WIDTH: load data, valid with `d_rvalid_o`; unchanged by stores
- `d_err_o` out 1: data fault, valid with `d_rvalid_o`
- `mem_addr_o` out WIDTH: memory system address
- `mem_wdata_o` out WIDTH: memory system write data
- `mem_we_o` out 1: memory system write enable
- `mem_rdata_i` in WIDTH: memory system read data, combinational from `mem_addr_o`
- `conflict_cnt_o` out CNT_W: saturating count of cycles in which a grant is issued while both requests are pending

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE and RESP accept a request. With only one request pending, that port wins. With both pending, the port not granted last time wins. The `last` flag resets to DATA, so the first conflict after reset goes to fetch.
- Acceptance: the winner's `*_gnt_o` is high combinationally in that cycle. The address, we, wdata and source are registered and the state moves to ACCESS. With no request pending, the state moves to (or stays in) IDLE.
- Fault check at acceptance:
  - Any address with `addr[1:0] != 0` faults.
  - A store with `d_addr_i < DATA_BASE` faults (ROM write).
  - A faulting request still passes through ACCESS, with `mem_we_o`=0, and responds with err=1.
- ACCESS: `mem_addr_o`/`mem_wdata_o` are driven from the registers. `mem_we_o`=1 only for a non-faulting store. At the clock edge, `mem_rdata_i` is captured into the source port's rdata register (loads and fetches only). State moves to RESP.
- RESP: the source port's rvalid is high for exactly one cycle, with its err. The other port's rvalid stays 0.
- `conflict_cnt_o` increments on each accepting cycle where `if_req_i && d_req_i`, and saturates at all-ones.

## Timing
- Accept in cycle N, ACCESS in N+1, rvalid in N+2. Peak throughput is one access per 2 cycles, because RESP overlaps the next acceptance.
- A store commits at the rising edge ending ACCESS.
- Reset values: state IDLE, `last`=DATA, all gnt/rvalid/err 0, `mem_we_o` 0, `mem_addr_o`/`mem_wdata_o` 0, rdata registers 0, counter 0.
- Reset asserted mid-access: the next state is IDLE. Any in-flight access is dropped with no rvalid, and `mem_we_o` is 0 from the next cycle. A store whose ACCESS edge coincides with reset is not committed (we gated by reset).
- A request deasserted before grant is simply not served. No gnt is issued while in ACCESS.

## Structure
- Package `mem_pkg`: state enum (IDLE/ACCESS/RESP), source enum (SRC_IF/SRC_D), `DATA_BASE` default, word-alignment helper constant.
- Sub-module `rr_arbiter2`: 2-input round-robin arbiter with a registered `last` flag. Inputs are two requests and an enable; outputs are one-hot grants.

## Test plan
- Fetch only, `if_addr_i`=0x0040_0000, ROM word 0xDEAD_BEEF -> `if_gnt_o` in N, `mem_addr_o`=0x0040_0000 in N+1, `if_rvalid_o`=1 with `if_rdata_o`=0xDEAD_BEEF in N+2.
- Store 0x1234_5678 to 0x1000_0004, then load 0x1000_0004 -> `mem_we_o` high for exactly one cycle; load returns 0x1234_5678 with `d_err_o`=0.
- Both requests held continuously for 6 grants -> grant order IF, D, IF, D, IF, D; `conflict_cnt_o`=6.
- Store to 0x0000_0010 and load from 0x1000_0002 -> each returns `d_rvalid_o`=1 with `d_err_o`=1; `mem_we_o` never asserts; RAM unchanged.
- Reset pulsed during ACCESS of a store -> no rvalid, no write committed, all outputs zero next cycle, and the next fetch is served normally.
